instr_mem_loader: RTL



---
 rtl/instr_mem_loader_if.sv | 19 +
 rtl/instr_mem_loader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-stream handshake carrying framed bytes from the UART receiver
// into the instruction memory loader.
interface instr_mem_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Frames A5/N/data bytes into LE words and writes them to instruction RAM.
// LOADER_CHECKSUM_EN adds a trailing mod-256 sum byte check.
module instr_mem_loader #(
  parameter int unsigned MAX_WORDS  = 32,
  parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  instr_mem_loader_if.slave rx,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [7:0]  words_loaded
);

  localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CSUM,
`endif
    FINISH
  } state_t;

  state_t      state;
  logic        rdy_q;
  logic [7:0]  n_q;
  logic [1:0]  byte_idx;
  logic [23:0] buf_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum_q;
`endif

  logic acc;
  assign acc         = rx.rx_valid && rdy_q;
  assign rx.rx_ready = rdy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rdy_q        <= 1'b0;
      n_q          <= '0;
      byte_idx     <= '0;
      buf_q        <= '0;
      imem_we      <= 1'b0;
      imem_waddr   <= START_ADDR;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          rdy_q <= 1'b1;
          if (acc && rx.rx_data == 8'hA5) begin
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            cpu_hold     <= 1'b1;
            state        <= LEN;
          end
        end
        LEN: begin
          if (acc) begin
            if (rx.rx_data == 8'd0 || rx.rx_data > MAX_N) begin
              load_error <= 1'b1;
              cpu_hold   <= 1'b0;
              state      <= IDLE;
            end else begin
              n_q      <= rx.rx_data;
              byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
              sum_q    <= '0;
`endif
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (acc) begin
            // Shift in from the top so byte 0 ends up in bits [7:0]
            buf_q    <= {rx.rx_data, buf_q[23:8]};
            byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= sum_q + rx.rx_data;
`endif
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {rx.rx_data, buf_q};
              imem_waddr <= START_ADDR
                          + {22'd0, words_loaded, 2'b00};
              rdy_q      <= 1'b0;
              state      <= WRITE;
            end
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 8'd1;
          if (words_loaded + 8'd1 == n_q) begin
`ifdef LOADER_CHECKSUM_EN
            rdy_q <= 1'b1;
            state <= CSUM;
`else
            state <= FINISH;
`endif
          end else begin
            rdy_q <= 1'b1;
            state <= DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (acc) begin
            if (rx.rx_data == sum_q) begin
              rdy_q <= 1'b0;
              state <= FINISH;
            end else begin
              load_error <= 1'b1;
              cpu_hold   <= 1'b0;
              state      <= IDLE;
            end
          end
        end
`endif
        FINISH: begin
          load_done <= 1'b1;
          cpu_hold  <= 1'b0;
          rdy_q     <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
